data_path: RTL and testbench

- Register-transfer datapath of the 8-bit computer, directly downstream of the control unit.
- Consumes every control strobe and select the control unit drives, and returns IR and CCR_Result to it.
- Holds IR, MAR, PC, A, B and CCR, the two internal buses and the ALU.
- Presents the address and write data to the memory system.

---
 rtl/data_path_pkg.sv | 41 ++++
 rtl/data_path_alu_core.sv | 75 +++++++
 rtl/data_path.sv | 112 +++++++++++
 tb/tb_data_path.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
// data_path_pkg: shared encodings for the 8-bit computer datapath.
// Rev 1.0 - initial release.
`default_nettype none

package data_path_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        BUS1_PC   = 2'b00,
        BUS1_A    = 2'b01,
        BUS1_B    = 2'b10,
        BUS1_ZERO = 2'b11
    } bus1_sel_e;

    typedef enum logic [1:0] {
        BUS2_ALU  = 2'b00,
        BUS2_BUS1 = 2'b01,
        BUS2_MEM  = 2'b10,
        BUS2_ZERO = 2'b11
    } bus2_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_INC = 3'b100,
        ALU_DEC = 3'b101,
        ALU_XOR = 3'b110,
        ALU_SHL = 3'b111
    } alu_sel_e;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

endpackage

`default_nettype wire

// File: rtl/data_path_alu_core.sv
// alu_core: combinational ALU with {N,Z,V,C} flags.
// XOR/SHL on codes 110/111 exist only when DATA_PATH_EXT_ALU_EN is defined. Rev 1.0.
`default_nettype none

module alu_core
    import data_path_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [2:0]        sel_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        nzvc_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]   ext;
    logic [DATA_W-1:0] res;
    logic              v;
    logic              c;

    always_comb begin
        ext = '0;
        res = '0;
        v   = 1'b0;
        c   = 1'b0;
        case (sel_i)
            ALU_ADD: begin
                ext = {1'b0, x_i} + {1'b0, y_i};
                res = ext[MSB:0];
                c   = ext[DATA_W];
                v   = (x_i[MSB] == y_i[MSB]) && (res[MSB] != x_i[MSB]);
            end
            ALU_SUB: begin
                res = x_i - y_i;
                c   = (x_i < y_i);
                v   = (x_i[MSB] != y_i[MSB]) && (res[MSB] != x_i[MSB]);
            end
            ALU_AND: res = x_i & y_i;
            ALU_OR:  res = x_i | y_i;
            ALU_INC: begin
                ext = {1'b0, x_i} + (DATA_W+1)'(1);
                res = ext[MSB:0];
                c   = ext[DATA_W];
                v   = !x_i[MSB] && res[MSB];
            end
            ALU_DEC: begin
                res = x_i - DATA_W'(1);
                c   = (x_i == '0);
                v   = x_i[MSB] && !res[MSB];
            end
`ifdef DATA_PATH_EXT_ALU_EN
            ALU_XOR: res = x_i ^ y_i;
            ALU_SHL: begin
                res = {x_i[MSB-1:0], 1'b0};
                c   = x_i[MSB];
                v   = x_i[MSB] ^ x_i[MSB-1];
            end
`endif
            // Without the extension, the upper codes are legal no-ops yielding zero.
            default: res = '0;
        endcase
    end

    assign result_o      = res;
    assign nzvc_o[CCR_N] = res[MSB];
    assign nzvc_o[CCR_Z] = (res == '0);
    assign nzvc_o[CCR_V] = v;
    assign nzvc_o[CCR_C] = c;

endmodule

`default_nettype wire

// File: rtl/data_path.sv
// data_path: IR/MAR/PC/A/B/CCR registers, Bus1/Bus2 muxes and ALU of the 8-bit computer.
// Rev 1.0 - initial release.
`default_nettype none

module data_path
    import data_path_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IR_Load,
    input  logic              MAR_Load,
    input  logic              PC_Load,
    input  logic              PC_Inc,
    input  logic              A_Load,
    input  logic              B_Load,
    input  logic              CCR_Load,
    input  logic [2:0]        ALU_Sel,
    input  logic [1:0]        Bus1_Sel,
    input  logic [1:0]        Bus2_Sel,
    input  logic [DATA_W-1:0] from_memory,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] IR,
    output logic [3:0]        CCR_Result
);

    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] a_q,   a_d;
    logic [DATA_W-1:0] b_q,   b_d;
    logic [3:0]        ccr_q, ccr_d;

    logic [DATA_W-1:0] bus1;
    logic [DATA_W-1:0] bus2;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_nzvc;

    always_comb begin
        bus1 = '0;
        case (Bus1_Sel)
            BUS1_PC:   bus1 = pc_q;
            BUS1_A:    bus1 = a_q;
            BUS1_B:    bus1 = b_q;
            default:   bus1 = '0;
        endcase
    end

    always_comb begin
        bus2 = '0;
        case (Bus2_Sel)
            BUS2_ALU:  bus2 = alu_result;
            BUS2_BUS1: bus2 = bus1;
            BUS2_MEM:  bus2 = from_memory;
            default:   bus2 = '0;
        endcase
    end

    alu_core #(
        .DATA_W   (DATA_W)
    ) u_alu (
        .x_i      (bus1),
        .y_i      (b_q),
        .sel_i    (ALU_Sel),
        .result_o (alu_result),
        .nzvc_o   (alu_nzvc)
    );

    always_comb begin
        ir_d  = IR_Load  ? bus2 : ir_q;
        mar_d = MAR_Load ? bus2 : mar_q;
        a_d   = A_Load   ? bus2 : a_q;
        b_d   = B_Load   ? bus2 : b_q;
        ccr_d = CCR_Load ? alu_nzvc : ccr_q;
        // A direct load beats increment so a jump target is never off by one.
        if (PC_Load)
            pc_d = bus2;
        else if (PC_Inc)
            pc_d = pc_q + ADDR_W'(1);
        else
            pc_d = pc_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ir_q  <= '0;
            mar_q <= '0;
            pc_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ccr_q <= '0;
        end else begin
            ir_q  <= ir_d;
            mar_q <= mar_d;
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ccr_q <= ccr_d;
        end
    end

    assign address    = mar_q;
    assign to_memory  = bus1;
    assign IR         = ir_q;
    assign CCR_Result = ccr_q;

endmodule

`default_nettype wire

// File: tb/tb_data_path.sv
// tb_data_path: directed vectors against hand-computed datapath results.
`default_nettype none

module tb_data_path;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic [7:0] from_memory;
    logic [7:0] address, to_memory, IR;
    logic [3:0] CCR_Result;

    int n_checks = 0;
    int n_pass   = 0;

    data_path dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .IR_Load     (IR_Load),
        .MAR_Load    (MAR_Load),
        .PC_Load     (PC_Load),
        .PC_Inc      (PC_Inc),
        .A_Load      (A_Load),
        .B_Load      (B_Load),
        .CCR_Load    (CCR_Load),
        .ALU_Sel     (ALU_Sel),
        .Bus1_Sel    (Bus1_Sel),
        .Bus2_Sel    (Bus2_Sel),
        .from_memory (from_memory),
        .address     (address),
        .to_memory   (to_memory),
        .IR          (IR),
        .CCR_Result  (CCR_Result)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    endtask

    task automatic idle();
        IR_Load = 0; MAR_Load = 0; PC_Load = 0; PC_Inc = 0;
        A_Load = 0; B_Load = 0; CCR_Load = 0;
        ALU_Sel = 3'b000; Bus1_Sel = 2'b00; Bus2_Sel = 2'b11;
        from_memory = 8'h00;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        idle(); A_Load = 1; Bus2_Sel = 2'b10; from_memory = v; step();
    endtask

    task automatic load_b(input logic [7:0] v);
        idle(); B_Load = 1; Bus2_Sel = 2'b10; from_memory = v; step();
    endtask

    task automatic load_pc(input logic [7:0] v);
        idle(); PC_Load = 1; Bus2_Sel = 2'b10; from_memory = v; step();
    endtask

    // A = a, B = b, then A <= ALU(A,B) with CCR load; observe A through Bus1.
    task automatic alu_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sel, input logic [7:0] er, input logic [3:0] ec);
        load_a(a);
        load_b(b);
        idle(); ALU_Sel = sel; Bus1_Sel = 2'b01; Bus2_Sel = 2'b00;
        A_Load = 1; CCR_Load = 1; step();
        idle(); Bus1_Sel = 2'b01; #1;
        check({tag, "_res"}, to_memory, er);
        check({tag, "_ccr"}, {4'h0, CCR_Result}, {4'h0, ec});
    endtask

    initial begin
        idle();
        IR_Load = 1; MAR_Load = 1; PC_Load = 1; A_Load = 1; B_Load = 1; CCR_Load = 1;
        Bus2_Sel = 2'b10; from_memory = 8'hAA;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ir",   IR, 8'h00);
            check("rst_addr", address, 8'h00);
            check("rst_ccr",  {4'h0, CCR_Result}, 8'h00);
            check("rst_bus1", to_memory, 8'h00);
            step();
        end
        Reset = 1'b1;

        idle(); MAR_Load = 1; Bus1_Sel = 2'b00; Bus2_Sel = 2'b01; step();
        check("mar_pc0", address, 8'h00);
        idle(); MAR_Load = 1; Bus2_Sel = 2'b10; from_memory = 8'h5A; step();
        check("mar_mem", address, 8'h5A);

        // Fetch
        load_pc(8'h05);
        idle(); IR_Load = 1; PC_Inc = 1; Bus2_Sel = 2'b10; from_memory = 8'h86; step();
        idle(); #1;
        check("fetch_ir", IR, 8'h86);
        check("fetch_pc", to_memory, 8'h06);

        alu_op("add_ovf", 8'h7F, 8'h01, 3'b000, 8'h80, 4'b1010);
        alu_op("sub_zero", 8'h05, 8'h05, 3'b001, 8'h00, 4'b0100);
        alu_op("sub_borrow", 8'h00, 8'h01, 3'b001, 8'hFF, 4'b1001);
        alu_op("and", 8'hF0, 8'h3C, 3'b010, 8'h30, 4'b0000);
        alu_op("or", 8'h80, 8'h01, 3'b011, 8'h81, 4'b1000);
        alu_op("inc_wrap", 8'hFF, 8'h00, 3'b100, 8'h00, 4'b0101);
        alu_op("dec_ovf", 8'h80, 8'h00, 3'b101, 8'h7F, 4'b0010);
`ifdef DATA_PATH_EXT_ALU_EN
        alu_op("xor", 8'hF0, 8'h3C, 3'b110, 8'hCC, 4'b1000);
        alu_op("shl", 8'hC0, 8'h00, 3'b111, 8'h80, 4'b1001);
`else
        alu_op("op110", 8'hF0, 8'h3C, 3'b110, 8'h00, 4'b0100);
        alu_op("op111", 8'hC0, 8'h00, 3'b111, 8'h00, 4'b0100);
`endif

        // CCR holds without CCR_Load even though the ALU result changes
        alu_op("ccr_set", 8'h7F, 8'h01, 3'b000, 8'h80, 4'b1010);
        idle(); ALU_Sel = 3'b010; Bus1_Sel = 2'b01; Bus2_Sel = 2'b00; A_Load = 1; step();
        idle(); Bus1_Sel = 2'b01; #1;
        check("hold_res", to_memory, 8'h00);
        check("hold_ccr", {4'h0, CCR_Result}, 8'h0A);

        // PC wrap and priority
        load_pc(8'hFF);
        idle(); PC_Inc = 1; step();
        idle(); #1;
        check("pc_wrap", to_memory, 8'h00);
        idle(); PC_Load = 1; PC_Inc = 1; Bus2_Sel = 2'b10; from_memory = 8'h40; step();
        idle(); #1;
        check("pc_prio", to_memory, 8'h40);

        // Simultaneous loads share Bus2
        idle(); MAR_Load = 1; PC_Load = 1; Bus2_Sel = 2'b10; from_memory = 8'h77; step();
        idle(); #1;
        check("dual_mar", address, 8'h77);
        check("dual_pc", to_memory, 8'h77);

        // Store path and asynchronous reset mid-cycle
        load_b(8'h3C);
        idle(); Bus1_Sel = 2'b10; #1;
        check("store_b", to_memory, 8'h3C);
        #2 Reset = 1'b0;
        #1;
        check("arst_b",    to_memory, 8'h00);
        check("arst_addr", address, 8'h00);
        check("arst_ir",   IR, 8'h00);
        Reset = 1'b1;
        idle(); PC_Inc = 1; step();
        idle(); #1;
        check("post_rst_pc", to_memory, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
